// File: rtl/ir_sm_decode.sv
`default_nettype none
// ============================================================================
//  Module   : ir_sm_decode
//  Purpose  : Instruction register, fetch/execute machine-state toggle,
//             carry/zero flag registers, fetched-instruction counter and
//             one-hot combinational instruction decode for a small CPU.
//  Ports    : clk, rst (async, active-high)
//             ins[7:0], ir_ld      - instruction byte and IR load strobe
//             sm_en                - machine-state toggle enable
//             cf_en, zf_en         - flag update enables (execute state only)
//             alu_cf, alu_zf       - flag sources from ALU/shifter
//             ir[7:0], sm          - instruction register, machine state
//             movea..halt          - one-hot decode of ir
//             cf, zf               - registered flags
//             icount[7:0]          - fetched-instruction counter
//             illegal              - ir holds an unassigned encoding
//  Config   : ILLEGAL_TRAP_EN - when defined, unassigned encodings decode as
//             halt and raise illegal; otherwise they decode as nop and
//             illegal is tied low.
//  Revision : 1.0 - initial release
// ============================================================================
module ir_sm_decode (
   input  logic       clk,
   input  logic       rst,
   input  logic [7:0] ins,
   input  logic       ir_ld,
   input  logic       sm_en,
   input  logic       cf_en,
   input  logic       zf_en,
   input  logic       alu_cf,
   input  logic       alu_zf,
   output logic [7:0] ir,
   output logic       sm,
   output logic       movea,
   output logic       moveb,
   output logic       movec,
   output logic       add,
   output logic       sub,
   output logic       and1,
   output logic       not1,
   output logic       rsr,
   output logic       rsl,
   output logic       jmp,
   output logic       jz,
   output logic       jc,
   output logic       in1,
   output logic       out1,
   output logic       nop,
   output logic       halt,
   output logic       cf,
   output logic       zf,
   output logic [7:0] icount,
   output logic       illegal
);

   typedef enum logic {
      ST_FETCH = 1'b0,
      ST_EXEC  = 1'b1
   } state_t;

   state_t state;
   logic   unassigned;

   // All architectural state. Flag updates look at the state before the
   // edge, so a flag write lands in the execute cycle even if sm toggles
   // back to fetch on the same edge.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state  <= ST_FETCH;
         ir     <= 8'h00;
         icount <= 8'h00;
         cf     <= 1'b0;
         zf     <= 1'b0;
      end else begin
         if (sm_en) begin
            state <= (state == ST_FETCH) ? ST_EXEC : ST_FETCH;
         end
         if (ir_ld) begin
            ir     <= ins;
            icount <= icount + 8'd1;
         end
         if ((state == ST_EXEC) && cf_en) begin
            cf <= alu_cf;
         end
         if ((state == ST_EXEC) && zf_en) begin
            zf <= alu_zf;
         end
      end
   end

   assign sm = (state == ST_EXEC);

   // Zero-latency one-hot decode from the current ir.
   always_comb begin
      movea      = 1'b0;
      moveb      = 1'b0;
      movec      = 1'b0;
      add        = 1'b0;
      sub        = 1'b0;
      and1       = 1'b0;
      not1       = 1'b0;
      rsr        = 1'b0;
      rsl        = 1'b0;
      jmp        = 1'b0;
      jz         = 1'b0;
      jc         = 1'b0;
      in1        = 1'b0;
      out1       = 1'b0;
      nop        = 1'b0;
      halt       = 1'b0;
      unassigned = 1'b0;
      case (ir[7:4])
         4'b1100: movea = 1'b1;
         4'b1101: moveb = 1'b1;
         4'b1110: movec = 1'b1;
         4'b1001: add   = 1'b1;
         4'b0110: sub   = 1'b1;
         4'b1011: and1  = 1'b1;
         4'b0101: not1  = 1'b1;
         4'b1010: begin
            case (ir[1:0])
               2'b00:   rsr        = 1'b1;
               2'b11:   rsl        = 1'b1;
               default: unassigned = 1'b1;
            endcase
         end
         4'b0011: begin
            case (ir[1:0])
               2'b00:   jmp        = 1'b1;
               2'b01:   jz         = 1'b1;
               2'b10:   jc         = 1'b1;
               default: unassigned = 1'b1;
            endcase
         end
         4'b0010: in1   = 1'b1;
         4'b0100: out1  = 1'b1;
         4'b0000: nop   = 1'b1;
         4'b1000: halt  = 1'b1;
         default: unassigned = 1'b1;   // 0001, 0111, 1111
      endcase
`ifdef ILLEGAL_TRAP_EN
      // Trap: stop the machine on anything undefined.
      if (unassigned) halt = 1'b1;
`else
      // Tolerant: treat anything undefined as a no-operation.
      if (unassigned) nop = 1'b1;
`endif
   end

`ifdef ILLEGAL_TRAP_EN
   assign illegal = unassigned;
`else
   assign illegal = 1'b0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_ir_sm_decode.sv
`default_nettype none
// ============================================================================
//  Module   : tb_ir_sm_decode
//  Purpose  : Self-checking bench for ir_sm_decode. Directed scenarios plus
//             randomized steps, compared against a behavioural model.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_ir_sm_decode;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic [7:0] ins = 8'h00;
   logic       ir_ld = 1'b0, sm_en = 1'b0, cf_en = 1'b0, zf_en = 1'b0;
   logic       alu_cf = 1'b0, alu_zf = 1'b0;
   logic [7:0] ir, icount;
   logic       sm, cf, zf, illegal;
   logic       movea, moveb, movec, add, sub, and1, not1, rsr, rsl;
   logic       jmp, jz, jc, in1, out1, nop, halt;

   int compared   = 0;
   int mismatched = 0;

   // Behavioural model state
   int m_ir, m_sm, m_cf, m_zf, m_cnt;

   ir_sm_decode dut (
      .clk(clk), .rst(rst), .ins(ins), .ir_ld(ir_ld), .sm_en(sm_en),
      .cf_en(cf_en), .zf_en(zf_en), .alu_cf(alu_cf), .alu_zf(alu_zf),
      .ir(ir), .sm(sm),
      .movea(movea), .moveb(moveb), .movec(movec), .add(add), .sub(sub),
      .and1(and1), .not1(not1), .rsr(rsr), .rsl(rsl), .jmp(jmp), .jz(jz),
      .jc(jc), .in1(in1), .out1(out1), .nop(nop), .halt(halt),
      .cf(cf), .zf(zf), .icount(icount), .illegal(illegal)
   );

   always #5 clk = ~clk;

   // Bit positions in the packed decode vector below.
   localparam int B_MOVEA = 15, B_MOVEB = 14, B_MOVEC = 13, B_ADD = 12;
   localparam int B_SUB = 11, B_AND1 = 10, B_NOT1 = 9, B_RSR = 8, B_RSL = 7;
   localparam int B_JMP = 6, B_JZ = 5, B_JC = 4, B_IN1 = 3, B_OUT1 = 2;
   localparam int B_NOP = 1, B_HALT = 0;

   function automatic logic [15:0] dut_dec();
      return {movea, moveb, movec, add, sub, and1, not1, rsr, rsl,
              jmp, jz, jc, in1, out1, nop, halt};
   endfunction

   // Expected {illegal, decode[15:0]} from the opcode table.
   function automatic logic [16:0] exp_dec(input int op);
      int hi = (op >> 4) & 15;
      int lo = op & 3;
      int bitpos = -1;
      logic [16:0] r = '0;
      if      (hi == 12) bitpos = B_MOVEA;
      else if (hi == 13) bitpos = B_MOVEB;
      else if (hi == 14) bitpos = B_MOVEC;
      else if (hi == 9)  bitpos = B_ADD;
      else if (hi == 6)  bitpos = B_SUB;
      else if (hi == 11) bitpos = B_AND1;
      else if (hi == 5)  bitpos = B_NOT1;
      else if (hi == 10 && lo == 0) bitpos = B_RSR;
      else if (hi == 10 && lo == 3) bitpos = B_RSL;
      else if (hi == 3 && lo == 0)  bitpos = B_JMP;
      else if (hi == 3 && lo == 1)  bitpos = B_JZ;
      else if (hi == 3 && lo == 2)  bitpos = B_JC;
      else if (hi == 2)  bitpos = B_IN1;
      else if (hi == 4)  bitpos = B_OUT1;
      else if (hi == 0)  bitpos = B_NOP;
      else if (hi == 8)  bitpos = B_HALT;
      if (bitpos >= 0) begin
         r[bitpos] = 1'b1;
      end else begin
`ifdef ILLEGAL_TRAP_EN
         r[B_HALT] = 1'b1;
         r[16]     = 1'b1;
`else
         r[B_NOP]  = 1'b1;
`endif
      end
      return r;
   endfunction

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      compared++;
      assert (obs === expv) else begin
         mismatched++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
      end
   endtask

   task automatic check_all(input string tag);
      logic [16:0] e;
      e = exp_dec(m_ir);
      check({tag, ":sm"},      32'(sm),      32'(m_sm));
      check({tag, ":ir"},      32'(ir),      32'(m_ir));
      check({tag, ":icount"},  32'(icount),  32'(m_cnt));
      check({tag, ":cf"},      32'(cf),      32'(m_cf));
      check({tag, ":zf"},      32'(zf),      32'(m_zf));
      check({tag, ":decode"},  32'(dut_dec()), 32'(e[15:0]));
      check({tag, ":illegal"}, 32'(illegal), 32'(e[16]));
   endtask

   task automatic model_reset();
      m_ir = 0; m_sm = 0; m_cf = 0; m_zf = 0; m_cnt = 0;
   endtask

   // One clock edge with the given inputs; model advanced, then checked.
   task automatic step(input string tag, input logic [7:0] i_ins, input logic ld,
                       input logic se, input logic ce, input logic ze,
                       input logic ac, input logic az);
      ins = i_ins; ir_ld = ld; sm_en = se; cf_en = ce; zf_en = ze;
      alu_cf = ac; alu_zf = az;
      @(posedge clk);
      if (m_sm == 1 && ce) m_cf = int'(ac);
      if (m_sm == 1 && ze) m_zf = int'(az);
      if (ld) begin
         m_ir  = int'(i_ins);
         m_cnt = (m_cnt + 1) % 256;
      end
      if (se) m_sm = 1 - m_sm;
      #1;
      check_all(tag);
   endtask

   // Assert reset between edges and confirm it acts without a clock edge.
   task automatic async_reset(input string tag);
      #2;
      rst = 1'b1;
      model_reset();
      #1;
      check_all(tag);
      @(negedge clk);
      rst = 1'b0;
   endtask

   initial begin
      byte unsigned subs [6];
      model_reset();
      // Power-on reset
      repeat (2) @(posedge clk);
      #1;
      check_all("por");
      check("por:nop", 32'(nop), 32'd1);
      @(negedge clk);
      rst = 1'b0;

      // Fetch/execute of ADD
      step("fetch96", 8'h96, 1, 1, 0, 0, 0, 0);
      check("fetch96:add", 32'(add), 32'd1);
      check("fetch96:cnt", 32'(icount), 32'd1);
      step("exec96", 8'h00, 0, 1, 0, 0, 0, 0);
      check("exec96:sm", 32'(sm), 32'd0);

      // Flags: only in execute
      step("to_exec", 8'h00, 0, 1, 0, 0, 0, 0);
      step("flag_exec", 8'h00, 0, 1, 1, 0, 1, 1);
      check("flag_exec:cf", 32'(cf), 32'd1);
      check("flag_exec:zf", 32'(zf), 32'd0);
      step("flag_fetch", 8'h00, 0, 0, 1, 1, 0, 1);
      check("flag_fetch:cf", 32'(cf), 32'd1);
      check("flag_fetch:zf", 32'(zf), 32'd0);

      // Sub-decodes and an unassigned encoding
      subs = '{8'h30, 8'h31, 8'h32, 8'hA0, 8'hA3, 8'h33};
      foreach (subs[k]) step($sformatf("sub_%02h", subs[k]), subs[k], 1, 0, 0, 0, 0, 0);
      step("unassigned_A1", 8'hA1, 1, 0, 0, 0, 0, 0);
      step("unassigned_1F", 8'h1F, 1, 0, 0, 0, 0, 0);
      step("unassigned_F5", 8'hF5, 1, 0, 0, 0, 0, 0);

      // Randomized traffic
      for (int n = 0; n < 300; n++) begin
         step("rand", 8'($urandom), 1'($urandom), 1'($urandom), 1'($urandom),
              1'($urandom), 1'($urandom), 1'($urandom));
      end

      // Reset while in execute; first edge after release is a fetch
      if (m_sm == 0) step("pre_rst", 8'h00, 0, 1, 0, 0, 0, 0);
      async_reset("mid_exec_rst");
      step("post_rst", 8'h00, 0, 0, 1, 1, 1, 1);
      check("post_rst:cf", 32'(cf), 32'd0);

      // icount wrap
      for (int n = 0; n < 255; n++) begin
         ins = 8'($urandom); ir_ld = 1; sm_en = 0; cf_en = 0; zf_en = 0;
         @(posedge clk);
         m_ir = int'(ins); m_cnt = (m_cnt + 1) % 256;
         #1;
      end
      check("wrap:ff", 32'(icount), 32'hFF);
      step("wrap", 8'h00, 1, 0, 0, 0, 0, 0);
      check("wrap:00", 32'(icount), 32'h00);

      // Halt: freeze with sm_en=0
      step("halt_ld", 8'h80, 1, 1, 0, 0, 0, 0);
      check("halt_ld:halt", 32'(halt), 32'd1);
      for (int n = 0; n < 10; n++) step("halt_hold", 8'($urandom), 0, 0, 0, 0, 1, 1);
      check("halt_hold:sm", 32'(sm), 32'd1);
      check("halt_hold:ir", 32'(ir), 32'h80);
      check("halt_hold:cnt", 32'(icount), 32'h01);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/ir_sm_decode.md
IR_SM_DECODE -- requirements
Module: ir_sm_decode

Interface
REQ-001 SHALL have ports, clock and reset first:
- clk  in  1  system clock; all state updates on rising edge.
- rst  in  1  asynchronous, active-high reset.
- ins  in  8  instruction byte from RAM data bus.
- ir_ld  in  1  load strobe for the instruction register.
- sm_en  in  1  machine-state toggle enable; low freezes sm.
- cf_en  in  1  carry-flag update enable.
- zf_en  in  1  zero-flag update enable.
- alu_cf  in  1  carry from ALU/shifter.
- alu_zf  in  1  zero from ALU.
- ir  out  8  instruction register.
- sm  out  1  machine state; 0 = fetch, 1 = execute.
- movea, moveb, movec, add, sub, and1, not1, rsr, rsl, jmp, jz, jc, in1, out1, nop, halt  out  1 each  one-hot decode of ir.
- cf, zf  out  1 each  registered flags.
- icount  out  8  fetched-instruction counter.
- illegal  out  1  ir holds an unassigned encoding.

Function
REQ-002 SHALL hold sm in a flip-flop that toggles on each clk edge where sm_en=1 and holds otherwise.
REQ-003 SHALL load ir<=ins on a clk edge where ir_ld=1; SHALL hold otherwise.
REQ-004 SHALL increment icount by 1 on each edge where ir_ld=1; SHALL wrap 8'hFF->8'h00.
REQ-005 SHALL decode combinationally from the current ir, zero-latency, exactly one output high:
- ir[7:4]=1100 movea; 1101 moveb; 1110 movec.
- 1001 add; 0110 sub; 1011 and1; 0101 not1.
- 1010: ir[1:0]=00 rsr, 11 rsl.
- 0011: ir[1:0]=00 jmp, 01 jz, 10 jc.
- 0010 in1; 0100 out1; 0000 nop; 1000 halt.
REQ-006 SHALL treat as unassigned: ir[7:4] in {0001,0111,1111}, 1010 with ir[1:0] in {01,10}, and 0011 with ir[1:0]=11.
REQ-007 SHALL load cf<=alu_cf on an edge where sm=1 and cf_en=1; SHALL hold otherwise.
REQ-008 SHALL load zf<=alu_zf on an edge where sm=1 and zf_en=1; SHALL hold otherwise.
REQ-009 SHALL ignore cf_en and zf_en while sm=0.
REQ-010 With ir_ld=1 and sm_en=1 on the same edge, SHALL both load ir and toggle sm; the new decode applies from the next cycle.
REQ-011 On halt, the consumer drives sm_en=0; SHALL then hold sm=1, ir, cf, zf and icount until rst.

Reset
REQ-012 Asserting rst SHALL immediately force sm=0, ir=8'h00, cf=0, zf=0, icount=8'h00, independent of clk.
REQ-013 After reset, decode SHALL present nop=1 and all other decode outputs 0.
REQ-014 rst asserted mid-execute SHALL abandon the instruction; the first edge after release SHALL be a fetch.
REQ-015 Release of rst SHALL take effect on the next rising clk.

Configuration
REQ-016 Macro ILLEGAL_TRAP_EN:
- Defined: an unassigned encoding SHALL assert illegal=1 and decode as halt=1.
- Undefined: an unassigned encoding SHALL decode as nop=1, and illegal SHALL be tied 0.

Verification
REQ-017 Reset: rst=1 mid-cycle -> sm=0, ir=00, icount=00, cf=zf=0, nop=1, before the next clk edge.
REQ-018 Fetch/execute: ins=8'h96, ir_ld=1, sm_en=1 on one edge -> ir=96, add=1, sm=1, icount=01; next edge with ir_ld=0 -> sm=0, ir=96.
REQ-019 Flags: sm=1, cf_en=1, zf_en=0, alu_cf=1, alu_zf=1 -> cf=1, zf=0; repeat with sm=0 -> flags unchanged.
REQ-020 Sub-decode: ir=8'h30 -> jmp; 8'h31 -> jz; 8'h32 -> jc; 8'hA0 -> rsr; 8'hA3 -> rsl.
REQ-021 Illegal: ir=8'h33 -> with ILLEGAL_TRAP_EN, halt=1 and illegal=1; without it, nop=1 and illegal=0.
REQ-022 Wrap/halt: after 255 loads icount=FF, one more load -> 00; ir=8'h80 with sm_en=0 for 10 edges -> sm, ir, icount all unchanged.
